// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade driver.
// Optional ramp logic is controlled by the LED_FADE_RAMP_EN macro.
package led_pkg;

  localparam int NUM_LEDS         = 8;
  localparam int DEFAULT_PWM_BITS = 8;
  localparam int DEFAULT_PRESCALE = 50;

  // Relation of a channel's level to its target, exposed for debug
  typedef enum logic [1:0] {
    CH_HOLD = 2'd0,
    CH_UP   = 2'd1,
    CH_DOWN = 2'd2
  } ch_state_t;

endpackage

// File: rtl/led_fade_driver_channel.sv
// One PWM channel: level register, ramp step, duty compare and pin flop.
// With LED_FADE_RAMP_EN defined the level can walk one step per period
// toward its target; otherwise it loads the target at every boundary.
//
// state   | meaning
// CH_HOLD | level equals target, nothing to do
// CH_UP   | level below target, step +1 per boundary when fading
// CH_DOWN | level above target, step -1 per boundary when fading
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                boundary,
  input  logic                fade_en,
  input  logic [PWM_BITS-1:0] target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pin,
  output logic                mismatch
);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_nxt;

`ifdef LED_FADE_RAMP_EN
  ch_state_t state;

  // Classify the channel against its target; this picks the ramp direction
  always_comb begin
    if (level < target) begin
      state = CH_UP;
    end else if (level > target) begin
      state = CH_DOWN;
    end else begin
      state = CH_HOLD;
    end
  end

  // Single unit step toward target while fading, direct load otherwise
  always_comb begin
    level_nxt = target;
    if (fade_en) begin
      case (state)
        CH_UP:   level_nxt = level + PWM_BITS'(1);
        CH_DOWN: level_nxt = level - PWM_BITS'(1);
        default: level_nxt = level;
      endcase
    end
  end
`else
  logic unused_fade_en;
  assign unused_fade_en = fade_en;
  assign level_nxt      = target;
`endif

  // Level only moves at the end of a PWM period so a period never splits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
    end else if (boundary) begin
      level <= level_nxt;
    end
  end

  // Registered duty compare; level 0 never fires, PWM_MAX always does
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin <= 1'b0;
    end else begin
      pin <= (pwm_cnt < level);
    end
  end

  assign mismatch = (level != target);

endmodule

// File: rtl/led_fade_driver.sv
// LED pin driver: global-brightness PWM on each of the eight LED enables,
// with optional linear fading when built with LED_FADE_RAMP_EN.
// Holds the shared prescaler, PWM counter, boundary strobe and busy flag.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int PWM_BITS = DEFAULT_PWM_BITS,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] leds_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [PS_W-1:0]     presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                boundary;
  logic [NUM_LEDS-1:0] mismatch;

  assign tick     = (presc == PS_LAST);
  assign boundary = tick && (pwm_cnt == PWM_LAST);

  // Prescaler wraps after PRESCALE cycles, producing one tick per wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  // PWM counter runs 0..PWM_MAX-1 so a full-scale level stays high all period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      if (pwm_cnt == PWM_LAST) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic [PWM_BITS-1:0] target;
    assign target = leds_in[i] ? brightness : '0;

    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .boundary (boundary),
      .fade_en  (fade_en),
      .target   (target),
      .pwm_cnt  (pwm_cnt),
      .pin      (led_out[i]),
      .mismatch (mismatch[i])
    );
  end

  // Busy reflects any channel away from its current target
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= |mismatch;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver (PWM_BITS=4, PRESCALE=1).
// Expectations follow LED_FADE_RAMP_EN in the same way as the design.
module tb_led_fade_driver;

  localparam int PMAX = 15;

`ifdef LED_FADE_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b0;
  logic [7:0] leds_in    = 8'h00;
  logic [3:0] brightness = 4'h0;
  logic       fade_en    = 1'b0;
  logic [7:0] led_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  logic [7:0] pend_leds  = 8'h00;
  bit         pend_valid = 1'b0;

  always #5 clk = ~clk;

  led_fade_driver #(
    .PWM_BITS (4),
    .PRESCALE (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .leds_in    (leds_in),
    .brightness (brightness),
    .fade_en    (fade_en),
    .led_out    (led_out),
    .busy       (busy)
  );

  // Behavioural model: period phase is the cycle count since reset modulo
  // PWM_MAX; levels move once per period toward leds_in ? brightness : 0.
  int         m_level [8];
  int         m_cyc      = 0;
  int         last_phase = -1;
  logic [7:0] exp_led    = 8'h00;
  logic       exp_busy   = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc      = 0;
      last_phase = -1;
      exp_led    = 8'h00;
      exp_busy   = 1'b0;
      foreach (m_level[i]) m_level[i] = 0;
    end else begin
      int phase;
      int tgt;
      phase    = m_cyc % PMAX;
      exp_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tgt        = leds_in[i] ? int'(brightness) : 0;
        exp_led[i] = (phase < m_level[i]);
        if (m_level[i] != tgt) exp_busy = 1'b1;
        if (phase == PMAX - 1) begin
          if (RAMP && fade_en && m_level[i] < tgt)      m_level[i] = m_level[i] + 1;
          else if (RAMP && fade_en && m_level[i] > tgt) m_level[i] = m_level[i] - 1;
          else                                          m_level[i] = tgt;
        end
      end
      last_phase = phase;
      m_cyc      = m_cyc + 1;
    end
  end

  // Per-cycle comparison of pins and busy against the model
  always @(negedge clk) begin
    if (check_en) begin
      n_cmp++;
      if (led_out !== exp_led) begin
        n_bad++;
        $display("FAIL led_out t=%0t actual=%h required=%h", $time, led_out, exp_led);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_bad++;
        $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, exp_busy);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Count high cycles of pins 0 and 7 over one whole PWM period that starts
  // after a boundary; a pending leds_in change lands before the closing one.
  task automatic measure(input bit fresh, output int d0, output int d7);
    int guard;
    guard = 0;
    d0 = 0;
    d7 = 0;
    if (fresh) @(negedge clk);
    while (last_phase != PMAX - 1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("period align timeout", 32'(guard), 32'd0);
    for (int k = 0; k < PMAX; k++) begin
      @(negedge clk);
      d0 += int'(led_out[0]);
      d7 += int'(led_out[7]);
      if (k == PMAX - 2 && pend_valid) begin
        leds_in    = pend_leds;
        pend_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int d7;

    repeat (3) @(negedge clk);
    check("reset led_out", 32'(led_out), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check_en = 1'b1;
    reset_n  = 1'b1;
    repeat (20) @(negedge clk);
    check("idle led_out", 32'(led_out), 32'h0);
    check("idle busy", 32'(busy), 32'h0);

    // Jump to full scale on LED 0
    fade_en = 1'b0; brightness = 4'd15; leds_in = 8'h01;
    measure(1'b1, d0, d7);
    check("jump full d0", 32'(d0), 32'd15);
    check("jump full d7", 32'(d7), 32'd0);
    check("jump full busy", 32'(busy), 32'd0);

    // Partial duty on LEDs 0 and 7
    brightness = 4'd5; leds_in = 8'h81;
    measure(1'b1, d0, d7);
    check("duty5 d0", 32'(d0), 32'd5);
    check("duty5 d7", 32'(d7), 32'd5);

    // Back to dark, then ramp LED 0 up, reversing at level 7
    leds_in = 8'h00;
    measure(1'b1, d0, d7);
    check("dark d0", 32'(d0), 32'd0);
    fade_en = 1'b1; brightness = 4'd15; leds_in = 8'h01;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) begin
        pend_leds  = 8'h00;
        pend_valid = 1'b1;
      end
      measure(k == 1, d0, d7);
      check($sformatf("ramp up d0 k=%0d", k), 32'(d0), RAMP ? 32'(k) : 32'd15);
      check($sformatf("ramp up busy k=%0d", k), 32'(busy), (k == 7 || RAMP) ? 32'd1 : 32'd0);
    end
    for (int j = 1; j <= 7; j++) begin
      measure(1'b0, d0, d7);
      check($sformatf("ramp down d0 j=%0d", j), 32'(d0), RAMP ? 32'(7 - j) : 32'd0);
    end
    check("model level after reversal", 32'(m_level[0]), 32'd0);
    check("busy after reversal", 32'(busy), 32'd0);

    // Full fade 0 -> 15
    leds_in = 8'h01;
    for (int k = 1; k <= 15; k++) begin
      measure(k == 1, d0, d7);
      check($sformatf("full ramp d0 k=%0d", k), 32'(d0), RAMP ? 32'(k) : 32'd15);
    end
    check("model level full", 32'(m_level[0]), 32'd15);
    check("busy after full ramp", 32'(busy), 32'd0);

    // Brightness change while holding
    brightness = 4'd9;
    measure(1'b1, d0, d7);
    check("hold dim d0", 32'(d0), RAMP ? 32'd14 : 32'd9);

    // Reset in the middle of a ramp
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid reset led_out", 32'(led_out), 32'h0);
    check("mid reset busy", 32'(busy), 32'h0);
    leds_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post reset led_out", 32'(led_out), 32'h0);
    check("post reset busy", 32'(busy), 32'h0);
    brightness = 4'd15; fade_en = 1'b1; leds_in = 8'h01;
    measure(1'b1, d0, d7);
    check("ramp resumes from 0", 32'(d0), RAMP ? 32'd1 : 32'd15);

    // Randomized inputs, checked every cycle by the model
    repeat (40) begin
      @(negedge clk);
      leds_in    = 8'($urandom);
      brightness = 4'($urandom_range(0, 15));
      fade_en    = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Output stage between the Avalon LED register and the board LED pins. It consumes the 8-bit LED enable vector written over Avalon-MM and drives each pin with a PWM waveform. Brightness is global, and each LED can optionally ramp linearly on and off. It replaces the direct register-to-pin connection on the top level.

## Interface
Parameters:
- PWM_BITS, 8: width of the intensity level and PWM counter; legal range 2..12.
- PRESCALE, 50: clk cycles per PWM tick; must be ≥ 1.

Ports:
- clk  in  1: system clock, single clock domain.
- reset_n  in  1: asynchronous, active-low reset.
- leds_in  in  8: LED enable vector from the Avalon LED register.
- brightness  in  PWM_BITS: global on-level.
- fade_en  in  1: 1 = ramp toward target, 0 = jump to target.
- led_out  out  8: PWM pin drive, registered.
- busy  out  1: registered; high while any level ≠ its target.

## Operation
- PWM_MAX = 2^PWM_BITS − 1.
- Prescaler counts 0..PRESCALE−1. `tick` is asserted on the cycle the prescaler equals PRESCALE−1, then the prescaler wraps to 0.
- pwm_cnt advances on each tick and counts 0..PWM_MAX−1, so one period = PWM_MAX ticks.
- `boundary` = tick && pwm_cnt == PWM_MAX−1, i.e. the last tick of a period.
- Per LED i, target[i] = leds_in[i] ? brightness : 0. Inputs are sampled only on boundary cycles.
- Per LED i, level[i] (PWM_BITS, unsigned) updates only on boundary:
  - fade_en = 0: level ← target.
  - fade_en = 1: level ← level ± 1 toward target, saturating at target. Each channel is implicitly in one of three states: HOLD (level == target), UP (level < target), DOWN (level > target).
- led_out[i] ← (pwm_cnt < level[i]) every clk cycle.
  - level = 0: pin always low.
  - level = PWM_MAX: pin always high.
- busy ← OR over i of (level[i] ≠ target[i]), using the current inputs.
- Target change mid-ramp: the ramp redirects at the next boundary, with no restart and no overshoot.
- brightness change during HOLD:
  - fade_en = 1: ramps to the new value.
  - fade_en = 0: jumps at the next boundary.

## Timing
- Reset (async assert, sync release by clk): prescaler, pwm_cnt, all levels, led_out and busy = 0.
- Reset mid-ramp: pins go low immediately. Ramping resumes from level 0 after release.
- Latency, input to level: input change → level change at the first boundary after the change.
- Latency, level to pin: one clk cycle (registered compare).
- Latency, busy: one clk cycle from an input or level change.
- Full fade 0 → PWM_MAX: PWM_MAX boundaries = PWM_MAX² × PRESCALE clk cycles.
- Simultaneous inputs change and boundary: the new values are used at that boundary.
- No handshake with upstream; leds_in is quasi-static register data in the same clock domain.

## Configuration
- Macro: LED_FADE_RAMP_EN.
- Defined: ramp logic is present and fade_en behaves as described in Operation.
- Undefined:
  - Ramp logic is removed and fade_en is ignored; the port remains for pin compatibility.
  - level always loads target at the boundary.
  - busy is high only from an input change until the next boundary.

## Structure
- Package led_pkg holds:
  - NUM_LEDS = 8;
  - default PWM_BITS and PRESCALE;
  - channel state encoding (HOLD/UP/DOWN) for debug visibility.
- Top level holds the prescaler, pwm_cnt, boundary generation and the busy reduction.
- Sub-module led_pwm_channel (level register, ramp step, compare, output flop) is instantiated NUM_LEDS times by a generate loop.

## Test plan
Bench parameters: PWM_BITS = 4, PRESCALE = 1, so PWM_MAX = 15 and period = 15 clk cycles.

- Reset asserted mid-run → led_out = 8'h00 and busy = 0 immediately; both stay 0 with leds_in = 0 after release.
- Jump to full: fade_en = 0, brightness = 15, leds_in = 8'h01 → after the next boundary, led_out[0] is constantly 1 and the other pins are 0; busy drops one cycle after the boundary.
- Partial duty: fade_en = 0, brightness = 5, leds_in = 8'h81 → led_out[0] and led_out[7] are high exactly 5 of every 15 cycles, in phase with pwm_cnt 0..4.
- Ramp up: LED_FADE_RAMP_EN defined, fade_en = 1, brightness = 15, leds_in 8'h00 → 8'h01 → level[0] increments once per period and reaches 15 after 15 boundaries; busy stays high until then.
- Ramp reversal: during the ramp-up test, leds_in → 8'h00 at level 7 → level decrements 7, 6, … to 0 over 7 boundaries with no overshoot.
- Macro undefined: the ramp-up stimulus with fade_en = 1 → level[0] jumps to 15 at the first boundary.
